// File: rtl/modc_field_join_if.sv
// Field-join bus: two valid/ready field streams in and one joined-pair stream out.
// The master drives the fields and o_ready. The slave (the join block) drives the readies and the pair.
interface modc_field_join_if #(
  parameter int unsigned A = 8,
  parameter int unsigned B = 9
);
  logic         f1_valid;
  logic [A-1:0] f1_data;
  logic         f1_ready;

  logic         f2_valid;
  logic [B-1:0] f2_data;
  logic         f2_ready;

  logic         o_valid;
  logic [A-1:0] o_i1;
  logic [B-1:0] o_i2;
  logic         o_ready;

  modport master (
    output f1_valid, f1_data, f2_valid, f2_data, o_ready,
    input  f1_ready, f2_ready, o_valid, o_i1, o_i2
  );

  modport slave (
    input  f1_valid, f1_data, f2_valid, f2_data, o_ready,
    output f1_ready, f2_ready, o_valid, o_i1, o_i2
  );
endinterface

// File: rtl/modc_field_join.sv
// Pairs the field-1 and field-2 streams in arrival order and presents each pair as a registered beat to modc.
// Optional MODC_FIELD_JOIN_STATS_EN adds the join_cnt and stall_cnt counters.
module modc_field_join #(
  parameter int unsigned A = 8,
  parameter int unsigned B = 9
) (
  input  logic             clk,
  input  logic             rst,
  modc_field_join_if.slave bus
`ifdef MODC_FIELD_JOIN_STATS_EN
  ,
  output logic [15:0]      join_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  logic         slot1_vld;
  logic [A-1:0] slot1_data;
  logic         slot2_vld;
  logic [B-1:0] slot2_data;

  logic         o_valid_q;
  logic [A-1:0] o_i1_q;
  logic [B-1:0] o_i2_q;

  logic         out_free;
  logic         join_fire;
  logic         f1_ready;
  logic         f2_ready;
  logic         acc1;
  logic         acc2;

  // Readies depend only on registered state and o_ready, never on the incoming valids.
  always_comb begin
    out_free  = !o_valid_q || bus.o_ready;
    join_fire = slot1_vld && slot2_vld && out_free;
    f1_ready  = !slot1_vld || join_fire;
    f2_ready  = !slot2_vld || join_fire;
    acc1      = bus.f1_valid && f1_ready;
    acc2      = bus.f2_valid && f2_ready;
  end

  assign bus.f1_ready = f1_ready;
  assign bus.f2_ready = f2_ready;
  assign bus.o_valid  = o_valid_q;
  assign bus.o_i1     = o_i1_q;
  assign bus.o_i2     = o_i2_q;

  // Field-1 slot: an accept in the join cycle reloads the slot, so it stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot1_vld  <= 1'b0;
      slot1_data <= '0;
    end else if (acc1) begin
      slot1_vld  <= 1'b1;
      slot1_data <= bus.f1_data;
    end else if (join_fire) begin
      slot1_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot2_vld  <= 1'b0;
      slot2_data <= '0;
    end else if (acc2) begin
      slot2_vld  <= 1'b1;
      slot2_data <= bus.f2_data;
    end else if (join_fire) begin
      slot2_vld  <= 1'b0;
    end
  end

  // Output register: the payload keeps its last value after the beat drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_i1_q    <= '0;
      o_i2_q    <= '0;
    end else if (join_fire) begin
      o_valid_q <= 1'b1;
      o_i1_q    <= slot1_data;
      o_i2_q    <= slot2_data;
    end else if (o_valid_q && bus.o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

`ifdef MODC_FIELD_JOIN_STATS_EN
  // Free-running counters that wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      join_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (join_fire) begin
        join_cnt <= join_cnt + 16'd1;
      end
      if (o_valid_q && !bus.o_ready) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_modc_field_join.sv
// Directed self-checking bench for modc_field_join (A=8, B=5).
`timescale 1ns/1ps
module tb_modc_field_join;
  localparam int unsigned A = 8;
  localparam int unsigned B = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  modc_field_join_if #(.A(A), .B(B)) bus ();
`ifdef MODC_FIELD_JOIN_STATS_EN
  logic [15:0] join_cnt;
  logic [15:0] stall_cnt;
`endif

  modc_field_join #(.A(A), .B(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MODC_FIELD_JOIN_STATS_EN
    ,
    .join_cnt (join_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [A-1:0] rx1[$];
  logic [B-1:0] rx2[$];
  int           rxc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pair that will be handed over at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.o_ready) begin
      rx1.push_back(bus.o_i1);
      rx2.push_back(bus.o_i2);
      rxc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx1.delete();
    rx2.delete();
    rxc.delete();
  endtask

  // Offers n beats on each field independently; o_ready is low for stream cycles [hold_lo, hold_hi).
  task automatic stream(input int n, input int base1, input int base2, input int hold_lo,
                        input int hold_hi, input int max_cyc, output bit seen_low);
    int i1 = 0;
    int i2 = 0;
    int c  = 0;
    bit a1, a2;
    bit held = 1'b0;
    logic [A-1:0] cap1 = '0;
    logic [B-1:0] cap2 = '0;
    seen_low = 1'b0;
    while ((i1 < n || i2 < n) && c < max_cyc) begin
      bus.f1_valid = (i1 < n);
      bus.f1_data  = A'(base1 + i1);
      bus.f2_valid = (i2 < n);
      bus.f2_data  = B'(base2 + i2);
      bus.o_ready  = !(c >= hold_lo && c < hold_hi);
      @(negedge clk);
      a1 = bus.f1_valid && bus.f1_ready;
      a2 = bus.f2_valid && bus.f2_ready;
      if (!bus.o_ready) begin
        if (held) begin
          chk("bp_hold_valid", 32'(bus.o_valid), 32'd1);
          chk("bp_hold_i1", 32'(bus.o_i1), 32'(cap1));
          chk("bp_hold_i2", 32'(bus.o_i2), 32'(cap2));
        end
        held = bus.o_valid;
        cap1 = bus.o_i1;
        cap2 = bus.o_i2;
        if (!bus.f1_ready && !bus.f2_ready) seen_low = 1'b1;
      end else begin
        held = 1'b0;
      end
      tick();
      if (a1) i1++;
      if (a2) i2++;
      c++;
    end
    if (i1 < n || i2 < n) begin
      chk("stream_f1_sent", 32'(i1), 32'(n));
      chk("stream_f2_sent", 32'(i2), 32'(n));
    end
    bus.f1_valid = 1'b0;
    bus.f2_valid = 1'b0;
    bus.o_ready  = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_low;
    rst          = 1'b1;
    bus.f1_valid = 1'b0;
    bus.f1_data  = '0;
    bus.f2_valid = 1'b0;
    bus.f2_data  = '0;
    bus.o_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_i1", 32'(bus.o_i1), 32'd0);
    chk("rst_o_i2", 32'(bus.o_i2), 32'd0);
    chk("rst_f1_ready", 32'(bus.f1_ready), 32'd1);
    chk("rst_f2_ready", 32'(bus.f2_ready), 32'd1);
    tick();

    // Simultaneous arrival: pair visible two cycles later
    clear_rx();
    bus.f1_valid = 1'b1; bus.f1_data = 8'hA5;
    bus.f2_valid = 1'b1; bus.f2_data = 5'h13;
    @(negedge clk);
    chk("sim_c0_f1_ready", 32'(bus.f1_ready), 32'd1);
    chk("sim_c0_f2_ready", 32'(bus.f2_ready), 32'd1);
    tick();
    bus.f1_valid = 1'b0;
    bus.f2_valid = 1'b0;
    @(negedge clk);
    chk("sim_c1_o_valid", 32'(bus.o_valid), 32'd0);
    chk("sim_c1_f1_ready", 32'(bus.f1_ready), 32'd1);
    chk("sim_c1_f2_ready", 32'(bus.f2_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("sim_c2_o_valid", 32'(bus.o_valid), 32'd1);
    chk("sim_c2_o_i1", 32'(bus.o_i1), 32'hA5);
    chk("sim_c2_o_i2", 32'(bus.o_i2), 32'h13);
    chk("sim_c2_f1_ready", 32'(bus.f1_ready), 32'd1);
    tick();
    repeat (3) tick();
    chk("sim_pair_count", 32'(rx1.size()), 32'd1);

    // Skew: field 1 waits five cycles for its partner
    clear_rx();
    bus.f1_valid = 1'b1; bus.f1_data = 8'h3C;
    @(negedge clk);
    tick();
    bus.f1_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        bus.f2_valid = 1'b1;
        bus.f2_data  = 5'h07;
      end
      @(negedge clk);
      chk($sformatf("skew_c%0d_f1_ready", c), 32'(bus.f1_ready), 32'd0);
      if (c == 5) chk("skew_c5_f2_ready", 32'(bus.f2_ready), 32'd1);
      tick();
    end
    bus.f2_valid = 1'b0;
    @(negedge clk);
    chk("skew_c6_o_valid", 32'(bus.o_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("skew_c7_o_valid", 32'(bus.o_valid), 32'd1);
    chk("skew_c7_o_i1", 32'(bus.o_i1), 32'h3C);
    chk("skew_c7_o_i2", 32'(bus.o_i2), 32'h07);
    tick();
    repeat (4) tick();
    chk("skew_pair_count", 32'(rx1.size()), 32'd1);

    // Streaming: 16 pairs, one per cycle after the first
    clear_rx();
    stream(16, 0, 0, 0, 0, 200, seen_low);
    repeat (4) tick();
    chk("stream_count", 32'(rx1.size()), 32'd16);
    if (rx1.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("stream_i1_%0d", k), 32'(rx1[k]), 32'(k));
        chk($sformatf("stream_i2_%0d", k), 32'(rx2[k]), 32'(k & 32'h1F));
        if (k > 0) chk($sformatf("stream_gap_%0d", k), 32'(rxc[k] - rxc[k-1]), 32'd1);
      end
    end

    // Back-pressure: o_ready low for six cycles mid-stream
    clear_rx();
    stream(10, 8'h40, 5'h10, 3, 9, 200, seen_low);
    repeat (4) tick();
    chk("bp_readies_dropped", 32'(seen_low), 32'd1);
    chk("bp_count", 32'(rx1.size()), 32'd10);
    if (rx1.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("bp_i1_%0d", k), 32'(rx1[k]), 32'(8'h40 + k));
        chk($sformatf("bp_i2_%0d", k), 32'(rx2[k]), 32'((5'h10 + k) & 32'h1F));
      end
    end

    // Reset mid-operation with a pending pair and a loaded slot
    clear_rx();
    bus.o_ready  = 1'b0;
    bus.f1_valid = 1'b1; bus.f1_data = 8'h11;
    bus.f2_valid = 1'b1; bus.f2_data = 5'h02;
    tick();
    bus.f1_valid = 1'b0;
    bus.f2_valid = 1'b0;
    tick();
    bus.f1_valid = 1'b1; bus.f1_data = 8'h55;
    @(negedge clk);
    chk("mrst_load_f1_ready", 32'(bus.f1_ready), 32'd1);
    tick();
    bus.f1_valid = 1'b0;
    @(negedge clk);
    chk("mrst_pre_o_valid", 32'(bus.o_valid), 32'd1);
    chk("mrst_pre_f1_ready", 32'(bus.f1_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("mrst_o_i1", 32'(bus.o_i1), 32'd0);
    chk("mrst_o_i2", 32'(bus.o_i2), 32'd0);
    chk("mrst_f1_ready", 32'(bus.f1_ready), 32'd1);
    chk("mrst_f2_ready", 32'(bus.f2_ready), 32'd1);
    tick();
    bus.o_ready  = 1'b1;
    bus.f2_valid = 1'b1; bus.f2_data = 5'h09;
    tick();
    bus.f2_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("mrst_lone_o_valid", 32'(bus.o_valid), 32'd0);
    chk("mrst_lone_f2_ready", 32'(bus.f2_ready), 32'd0);
    chk("mrst_lone_count", 32'(rx1.size()), 32'd0);
    tick();

`ifdef MODC_FIELD_JOIN_STATS_EN
    // Counters: 3 joins with 4 stall cycles, then wrap after 0xFFFF joins
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("stat_rst_join", 32'(join_cnt), 32'd0);
    chk("stat_rst_stall", 32'(stall_cnt), 32'd0);
    tick();
    stream(2, 1, 1, 0, 0, 100, seen_low);
    repeat (4) tick();
    bus.o_ready  = 1'b0;
    bus.f1_valid = 1'b1; bus.f1_data = 8'h21;
    bus.f2_valid = 1'b1; bus.f2_data = 5'h03;
    tick();
    bus.f1_valid = 1'b0;
    bus.f2_valid = 1'b0;
    tick();
    repeat (4) tick();
    bus.o_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("stat_join_3", 32'(join_cnt), 32'd3);
    chk("stat_stall_4", 32'(stall_cnt), 32'd4);
    tick();
    stream(65532, 0, 0, 0, 0, 70000, seen_low);
    repeat (4) tick();
    chk("stat_join_ffff", 32'(join_cnt), 32'hFFFF);
    stream(1, 0, 0, 0, 0, 100, seen_low);
    repeat (4) tick();
    chk("stat_join_wrap", 32'(join_cnt), 32'd0);
    clear_rx();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
